// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, used by the sync generator, the pixel
// renderer and the game logic so that they all agree on the frame geometry.
package vga_timing_pkg;

    localparam int COUNT_W = 10;
    typedef logic [COUNT_W-1:0] count_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Sync windows are half-open: [START, END)
    localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    function automatic logic inRange(input count_t value, input int lo, input int hi);
        return (int'(value) >= lo) && (int'(value) < hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-strobe input and raster timing outputs of the VGA sync generator.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic   PixelEnable;
    count_t HCount;
    count_t VCount;
    logic   HSync;
    logic   VSync;
    logic   Visible;
    logic   FrameTick;

    modport master (
        input  PixelEnable,
        output HCount,
        output VCount,
        output HSync,
        output VSync,
        output Visible,
        output FrameTick
    );

    modport slave (
        output PixelEnable,
        input  HCount,
        input  VCount,
        input  HSync,
        input  VSync,
        input  Visible,
        input  FrameTick
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter 0..TOTAL-1 with enable, carry-out on wrap and a
// registered [WIN_LO, WIN_HI) decode taken from the next count value.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL  = DEF_H_TOTAL,
    parameter int WIN_LO = DEF_H_SYNC_START,
    parameter int WIN_HI = DEF_H_SYNC_END
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   en_i,
    output count_t count_o,
    output count_t countNext_o,
    output logic   carry_o,
    output logic   inWindow_o
);

    localparam count_t LAST = count_t'(TOTAL - 1);

    count_t count_q, count_d;
    logic   inWindow_q, inWindow_d;
    logic   atLast;

    always_comb begin
        atLast     = (count_q == LAST);
        count_d    = count_q;
        if (en_i) begin
            count_d = atLast ? '0 : count_q + 1'b1;
        end
        inWindow_d = inRange(count_d, WIN_LO, WIN_HI);
    end

    // Window flag is decoded from count_d so it flips on the same edge as the count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q    <= '0;
            inWindow_q <= inRange('0, WIN_LO, WIN_HI);
        end else begin
            count_q    <= count_d;
            inWindow_q <= inWindow_d;
        end
    end

    assign count_o     = count_q;
    assign countNext_o = count_d;
    assign carry_o     = en_i && atLast;
    assign inWindow_o  = inWindow_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: horizontal and vertical counters advanced by the
// pixel strobe, with registered sync/visible flags and a start-of-vblank tick.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic           MasterClock,
    input  logic           Reset,
    vga_sync_gen_if.master bus
);

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    count_t hCount, hNext, vCount, vNext;
    logic   hCarry, unusedVCarry;
    logic   hSyncWin, vSyncWin;
    logic   visible_q, visible_d;
    logic   frameTick_q, frameTick_d;

    vga_axis_counter #(
        .TOTAL  (H_TOTAL),
        .WIN_LO (H_SYNC_START),
        .WIN_HI (H_SYNC_END)
    ) hAxis (
        .clk_i       (MasterClock),
        .rst_i       (Reset),
        .en_i        (bus.PixelEnable),
        .count_o     (hCount),
        .countNext_o (hNext),
        .carry_o     (hCarry),
        .inWindow_o  (hSyncWin)
    );

    // The vertical axis steps only when the horizontal axis wraps
    vga_axis_counter #(
        .TOTAL  (V_TOTAL),
        .WIN_LO (V_SYNC_START),
        .WIN_HI (V_SYNC_END)
    ) vAxis (
        .clk_i       (MasterClock),
        .rst_i       (Reset),
        .en_i        (hCarry),
        .count_o     (vCount),
        .countNext_o (vNext),
        .carry_o     (unusedVCarry),
        .inWindow_o  (vSyncWin)
    );

    always_comb begin
        visible_d   = inRange(hNext, 0, H_VISIBLE) && inRange(vNext, 0, V_VISIBLE);
        frameTick_d = hCarry && (int'(vNext) == V_VISIBLE);
    end

    // FrameTick is not held by a missing strobe: it lasts a single MasterClock cycle
    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            visible_q   <= 1'b1;
            frameTick_q <= 1'b0;
        end else begin
            visible_q   <= visible_d;
            frameTick_q <= frameTick_d;
        end
    end

    assign bus.HCount    = hCount;
    assign bus.VCount    = vCount;
    assign bus.HSync     = ~hSyncWin;
    assign bus.VSync     = ~vSyncWin;
    assign bus.Visible   = visible_q;
    assign bus.FrameTick = frameTick_q;

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The parameters SHALL be, one per line: name, default, meaning.
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch, pixels
- H_SYNC, 96, horizontal sync width, pixels
- H_BACK, 48, horizontal back porch, pixels
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BACK, 33, vertical back porch, lines
REQ-002 The ports SHALL be, one per line: name, direction, width, meaning.
- MasterClock  in  1  sole clock, 100 MHz
- Reset  in  1  synchronous, active-high reset
- PixelEnable  in  1  one-cycle strobe at pixel rate (25 MHz), produced by the clock divider
- HCount  out  10  current pixel column, 0..H_TOTAL-1
- VCount  out  10  current line, 0..V_TOTAL-1
- HSync  out  1  horizontal sync, active low
- VSync  out  1  vertical sync, active low
- Visible  out  1  high when HCount<H_VISIBLE and VCount<V_VISIBLE
- FrameTick  out  1  one-MasterClock pulse at the start of vertical blanking
REQ-003 The block SHALL have one clock, MasterClock; Reset SHALL be synchronous and active-high.

Function
REQ-004 H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525) SHALL be derived constants.
REQ-005 All state SHALL change only on MasterClock edges where PixelEnable=1; when PixelEnable=0, every output except FrameTick SHALL hold.
REQ-006 HCount SHALL increment by 1 per PixelEnable and wrap from H_TOTAL-1 to 0.
REQ-007 VCount SHALL increment only on the HCount wrap and wrap from V_TOTAL-1 to 0 on the same edge at which HCount wraps.
REQ-008 HSync SHALL be 0 exactly when H_VISIBLE+H_FRONT <= HCount < H_VISIBLE+H_FRONT+H_SYNC (656..751), and 1 otherwise.
REQ-009 VSync SHALL be 0 exactly when V_VISIBLE+V_FRONT <= VCount < V_VISIBLE+V_FRONT+V_SYNC (490..491), and 1 otherwise.
REQ-010 HSync, VSync and Visible SHALL be registered and decoded from the next-count values, so they change on the same edge as HCount/VCount, with zero-cycle skew relative to the counters.
REQ-011 FrameTick SHALL be 1 for exactly one MasterClock cycle: the cycle following the enabled edge on which (HCount,VCount) becomes (0,V_VISIBLE). It SHALL be 0 at all other times.
REQ-012 Counter widths SHALL be 10 bits; values >= H_TOTAL or >= V_TOTAL SHALL never appear.
REQ-013 A PixelEnable held high on consecutive cycles SHALL advance the counters on every cycle, with no skipped or merged strobes.

Reset
REQ-014 While Reset=1 at a MasterClock edge, regardless of PixelEnable, the outputs SHALL be HCount=0, VCount=0, HSync=1, VSync=1, Visible=1, FrameTick=0.
REQ-015 Reset asserted mid-line or mid-frame SHALL abort the frame; the first enabled edge after release SHALL produce HCount=1, VCount=0.

Structure
REQ-016 The timing defaults, the derived H_TOTAL/V_TOTAL, and the sync-window boundaries SHALL reside in a shared package, vga_timing_pkg, for reuse by the pixel renderer and the snake game logic.
REQ-017 A single sub-module, vga_axis_counter (wrap counter with enable, carry-out and range-decode output), SHALL be instantiated twice: once for the H axis and once for the V axis, with V enabled by the H carry.
REQ-018 The implementation SHALL be 120-400 lines of RTL, with no latches and no derived clocks.

Verification
REQ-019 Reset, then PixelEnable every 4th cycle for 800 strobes -> HCount returns to 0, VCount=1, and HSync is low for exactly 96 strobes beginning at HCount=656.
REQ-020 Run one full frame (420000 strobes) -> VSync is low for exactly 2 lines (VCount 490..491), FrameTick pulses exactly once, and (0,0) recurs after 420000 strobes.
REQ-021 Hold PixelEnable=0 for 1000 cycles mid-line at HCount=300 -> all outputs are frozen and FrameTick stays 0.
REQ-022 Assert Reset for 1 cycle at (HCount,VCount)=(700,491) with PixelEnable=1 -> the next cycle shows (0,0) with HSync=1, VSync=1, Visible=1.
REQ-023 Hold PixelEnable=1 continuously through (799,524) -> the next edge produces (0,0) with no counter value of 800 or 525 ever appearing.
REQ-024 Check Visible at (639,479)=1, (640,479)=0 and (0,480)=0 -> each value matches, with FrameTick=1 only in the cycle after (0,480) is reached.
